stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised successor to the stage-decode enable logic for the multicycle processor.
- Owns the stage counter itself rather than decoding an externally supplied stage.
- Adds run/idle control, a stall input, a variable-latency memory stage with timeout, a flush (refetch) and instruction accounting.
- Drives every datapath register enable and the instruction ROM read strobe.

Parameters:
- NUM_STAGES, 5, stages per instruction (legal 5..7); stage numbering is 1..NUM_STAGES.
- STAGE_W, 3, width of Stage output; must hold NUM_STAGES.
- MEM_STAGE, 4, stage that may wait on memory; legal range 4..NUM_STAGES-1.
- MEM_TIMEOUT, 15, maximum wait cycles in MEM_STAGE before fault.
- CNT_W, 16, width of instruction counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Run  in  1  level; permits instructions to start.
- Stall  in  1  freezes stage advance this cycle.
- Flush  in  1  abandons current instruction and refetches.
- Mem_Access  in  1  current instruction uses data memory; sampled only in MEM_STAGE.
- Mem_Ready  in  1  memory completed this cycle.
- Stage  out  STAGE_W  current stage number.
- IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable, ROM1_Read  out  1 each  register/ROM enables.
- Mem_Req  out  1  memory request active.
- Mem_Wait  out  1  stage held for memory.
- Instr_Done  out  1  single-cycle pulse per retired instruction.
- Instr_Count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- Fault  out  1  sticky memory-timeout flag.

Behaviour:
- FSM states:
  - IDLE: no enables; Stage held.
  - RUN: Stage advancing.
  - FAULT: sticky; exits only on Reset.
- Reset, from any state including mid-instruction:
  - state=IDLE, Stage=NUM_STAGES, Valid=0, wait counter=0, Instr_Count=0, Fault=0.
  - All enables, Mem_Req, Mem_Wait and Instr_Done=0.
- Transitions:
  - IDLE -> RUN when Run=1 (one-cycle latency). The first RUN cycle is at Stage=NUM_STAGES, so IR_Enable and ROM1_Read load the first instruction.
  - RUN -> IDLE at an instruction boundary: advance out of Stage=NUM_STAGES while Run=0. Stage then becomes 1 only if Run=1; otherwise it stays NUM_STAGES.
- advance = RUN & !Stall & !Mem_Wait.
- On advance: Stage <= (Stage==NUM_STAGES) ? 1 : Stage+1.
- Enable map: asserted only when advance=1 and Flush=0; an enable in stage k captures on the edge leaving k.
  - Stage 1: PC_Enable, RA_Enable, RB_Enable.
  - Stage 2: RZ_Enable, RM_Enable.
  - Stage 3: RY_Enable.
  - Stage NUM_STAGES: IR_Enable, ROM1_Read.
  - All other stages: none.
- Memory stage:
  - Mem_Req = RUN & Stage==MEM_STAGE & Mem_Access.
  - Mem_Wait = Mem_Req & !Mem_Ready.
  - The wait counter increments each Mem_Wait cycle and clears on leaving MEM_STAGE.
  - When the counter reaches MEM_TIMEOUT with Mem_Wait still 1: next state FAULT and Fault <= 1.
  - Mem_Ready arriving on the timeout cycle wins: no fault.
  - Stall during MEM_STAGE with Mem_Ready=1 holds the stage; Mem_Req stays high.
- Valid:
  - Set on advance out of stage 1.
  - Cleared on Flush, Reset and retirement.
- Retirement: Instr_Done = advance & Stage==NUM_STAGES & Valid. Instr_Count increments on the same edge and wraps from all-ones to 0.
- Flush:
  - Effective only in RUN with Stage in 2..NUM_STAGES-1.
  - Next Stage=NUM_STAGES, Valid=0, wait counter=0; all enables 0 that cycle.
  - Ignored in stage 1 and in stage NUM_STAGES.
- Priority: Reset > Fault > Flush > Mem_Wait > Stall > advance.
- Stall in IDLE or FAULT has no effect.

Decomposition:
- Shared package (stage_pkg):
  - FSM state enum {IDLE, RUN, FAULT}.
  - Stage role constants STG_FETCH=1, STG_DECODE=2, STG_EXECUTE=3.
  - Enable-vector bit indices for the eight enables.
- Sub-module stage_enable_decode: combinational map from Stage, advance and Flush to the eight enables, reused by later pipelined variants.
- Counters and FSM stay in the top module.

Test Plan:
1. Reset, then Run=1 with Mem_Access=0, 10 instructions -> Stage sequence 5,1,2,3,4,5 repeating; IR_Enable and ROM1_Read high only when Stage=5; Instr_Done 10 pulses after the first fetch instruction retires; Instr_Count=10.
2. Mem_Access=1 and Mem_Ready low 3 cycles in stage 4 -> Stage holds 4 for 3 cycles with Mem_Wait=1 and Mem_Req=1; advances on the 4th cycle; no enables during the wait.
3. Mem_Ready never asserted -> Fault=1 after 15 wait cycles; state FAULT; all enables 0 until Reset; Reset clears Fault and Instr_Count.
4. Flush in stage 3 -> next Stage=5, RY_Enable not asserted, Instr_Done not pulsed for the flushed instruction, refetch occurs (IR_Enable=1).
5. Stall held 2 cycles in stage 1, then Run dropped in stage 3 -> Stage holds 1 for 2 cycles with PC_Enable=0; the instruction completes, then IDLE with Stage=5.
6. CNT_W=4, run 17 instructions; Reset asserted mid-stage-2 -> Instr_Count wraps 15->0 then reaches 1; Reset returns Stage=5, all outputs 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the multicycle stage sequencer family.
package stage_pkg;

   // Sequencer operating mode
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAULT
   } seq_state_t;

   // Fixed stage roles; later stages are implementation-dependent
   localparam int unsigned STG_FETCH   = 1;
   localparam int unsigned STG_DECODE  = 2;
   localparam int unsigned STG_EXECUTE = 3;

   // Bit positions inside the enable vector
   localparam int unsigned EN_IR    = 0;
   localparam int unsigned EN_PC    = 1;
   localparam int unsigned EN_RA    = 2;
   localparam int unsigned EN_RB    = 3;
   localparam int unsigned EN_RZ    = 4;
   localparam int unsigned EN_RM    = 5;
   localparam int unsigned EN_RY    = 6;
   localparam int unsigned EN_ROM1  = 7;
   localparam int unsigned EN_COUNT = 8;

   typedef logic [EN_COUNT-1:0] en_vec_t;

endpackage

// File: rtl/stage_sequencer_enable_decode.sv
// Combinational map from the current stage to datapath register enables.
// An enable raised in stage k captures on the clock edge that leaves k.
module stage_enable_decode
   import stage_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned STAGE_W    = 3
) (
   input  logic [STAGE_W-1:0] stage,
   input  logic               advance,
   input  logic               flush,
   output en_vec_t            enables
);

   localparam logic [STAGE_W-1:0] S_FETCH   = STAGE_W'(STG_FETCH);
   localparam logic [STAGE_W-1:0] S_DECODE  = STAGE_W'(STG_DECODE);
   localparam logic [STAGE_W-1:0] S_EXECUTE = STAGE_W'(STG_EXECUTE);
   localparam logic [STAGE_W-1:0] S_LAST    = STAGE_W'(NUM_STAGES);

   // Enables only fire on a real advance that is not being flushed
   always_comb begin
      enables = '0;
      if (advance && !flush) begin
         if (stage == S_FETCH) begin
            enables[EN_PC] = 1'b1;
            enables[EN_RA] = 1'b1;
            enables[EN_RB] = 1'b1;
         end
         if (stage == S_DECODE) begin
            enables[EN_RZ] = 1'b1;
            enables[EN_RM] = 1'b1;
         end
         if (stage == S_EXECUTE) begin
            enables[EN_RY] = 1'b1;
         end
         if (stage == S_LAST) begin
            enables[EN_IR]   = 1'b1;
            enables[EN_ROM1] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: owns the stage counter, run/idle control, stall,
// variable-latency memory stage with timeout, flush and retirement count.
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 5,
   parameter int unsigned STAGE_W     = 3,
   parameter int unsigned MEM_STAGE   = 4,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Run,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               Mem_Access,
   input  logic               Mem_Ready,
   output logic [STAGE_W-1:0] Stage,
   output logic               IR_Enable,
   output logic               PC_Enable,
   output logic               RA_Enable,
   output logic               RB_Enable,
   output logic               RZ_Enable,
   output logic               RM_Enable,
   output logic               RY_Enable,
   output logic               ROM1_Read,
   output logic               Mem_Req,
   output logic               Mem_Wait,
   output logic               Instr_Done,
   output logic [CNT_W-1:0]   Instr_Count,
   output logic               Fault
);

   localparam int unsigned        WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [STAGE_W-1:0] S_FIRST    = STAGE_W'(STG_FETCH);
   localparam logic [STAGE_W-1:0] S_LAST     = STAGE_W'(NUM_STAGES);
   localparam logic [STAGE_W-1:0] S_MEM      = STAGE_W'(MEM_STAGE);
   localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   seq_state_t         state, state_next;
   logic [STAGE_W-1:0] stage_next;
   logic               valid, valid_next;
   logic [WAIT_W-1:0]  wait_cnt, wait_next;
   logic [CNT_W-1:0]   count_next;
   logic               fault_next;
   logic               running;
   logic               advance;
   logic               flush_hit;
   logic               timeout;
   en_vec_t            enables;

   // State register; synchronous reset wins over everything
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         Stage       <= S_LAST;
         valid       <= 1'b0;
         wait_cnt    <= '0;
         Instr_Count <= '0;
         Fault       <= 1'b0;
      end else begin
         state       <= state_next;
         Stage       <= stage_next;
         valid       <= valid_next;
         wait_cnt    <= wait_next;
         Instr_Count <= count_next;
         Fault       <= fault_next;
      end
   end

   // Control decode and next-state; priority fault > flush > wait > stall > advance
   always_comb begin
      running    = (state == RUN) && !Reset;
      Mem_Req    = running && (Stage == S_MEM) && Mem_Access;
      Mem_Wait   = Mem_Req && !Mem_Ready;
      advance    = running && !Stall && !Mem_Wait;
      flush_hit  = running && Flush && (Stage != S_FIRST) && (Stage != S_LAST);
      timeout    = Mem_Wait && (wait_cnt == WAIT_LIMIT);
      Instr_Done = advance && (Stage == S_LAST) && valid;

      state_next = state;
      stage_next = Stage;
      valid_next = valid;
      wait_next  = wait_cnt;
      count_next = Instr_Count;
      fault_next = Fault;

      unique case (state)
         IDLE: begin
            if (Run) state_next = RUN;
         end
         RUN: begin
            if (timeout) begin
               state_next = FAULT;
               fault_next = 1'b1;
            end else if (flush_hit) begin
               stage_next = S_LAST;
               valid_next = 1'b0;
               wait_next  = '0;
            end else if (Mem_Wait) begin
               wait_next = wait_cnt + 1'b1;
            end else if (advance) begin
               wait_next = '0;
               if (Stage == S_LAST) begin
                  // Instruction boundary: refetch only while Run is held
                  valid_next = 1'b0;
                  if (Run) stage_next = S_FIRST;
                  else     state_next = IDLE;
               end else begin
                  stage_next = Stage + 1'b1;
                  if (Stage == S_FIRST) valid_next = 1'b1;
               end
               if (Instr_Done) count_next = Instr_Count + 1'b1;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: state_next = IDLE;
      endcase
   end

   stage_enable_decode #(
      .NUM_STAGES (NUM_STAGES),
      .STAGE_W    (STAGE_W)
   ) u_enable_decode (
      .stage   (Stage),
      .advance (advance),
      .flush   (flush_hit),
      .enables (enables)
   );

   assign IR_Enable = enables[EN_IR];
   assign PC_Enable = enables[EN_PC];
   assign RA_Enable = enables[EN_RA];
   assign RB_Enable = enables[EN_RB];
   assign RZ_Enable = enables[EN_RZ];
   assign RM_Enable = enables[EN_RM];
   assign RY_Enable = enables[EN_RY];
   assign ROM1_Read = enables[EN_ROM1];

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer against a behavioural instruction model.
module tb_stage_sequencer;

   localparam int N    = 5;
   localparam int MEMS = 4;
   localparam int TMO  = 15;
   localparam int CW   = 4;

   logic          Clock;
   logic          Reset, Run, Stall, Flush, Mem_Access, Mem_Ready;
   logic [2:0]    Stage;
   logic          IR_Enable, PC_Enable, RA_Enable, RB_Enable;
   logic          RZ_Enable, RM_Enable, RY_Enable, ROM1_Read;
   logic          Mem_Req, Mem_Wait, Instr_Done, Fault;
   logic [CW-1:0] Instr_Count;

   stage_sequencer #(
      .NUM_STAGES  (N),
      .STAGE_W     (3),
      .MEM_STAGE   (MEMS),
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CW)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Run         (Run),
      .Stall       (Stall),
      .Flush       (Flush),
      .Mem_Access  (Mem_Access),
      .Mem_Ready   (Mem_Ready),
      .Stage       (Stage),
      .IR_Enable   (IR_Enable),
      .PC_Enable   (PC_Enable),
      .RA_Enable   (RA_Enable),
      .RB_Enable   (RB_Enable),
      .RZ_Enable   (RZ_Enable),
      .RM_Enable   (RM_Enable),
      .RY_Enable   (RY_Enable),
      .ROM1_Read   (ROM1_Read),
      .Mem_Req     (Mem_Req),
      .Mem_Wait    (Mem_Wait),
      .Instr_Done  (Instr_Done),
      .Instr_Count (Instr_Count),
      .Fault       (Fault)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int passed = 0;

   // Model of the instruction in flight
   int m_stage = N, m_waits = 0, m_count = 0;
   bit m_running = 0, m_faulted = 0, m_valid = 0;
   int n_stage, n_waits, n_count;
   bit n_running, n_faulted, n_valid;
   logic [18:0] exp_v;
   bit exp_done;

   function automatic logic [18:0] obs();
      return {Stage, IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable,
              RM_Enable, RY_Enable, ROM1_Read, Mem_Req, Mem_Wait, Instr_Done,
              Instr_Count, Fault};
   endfunction

   // Let inputs settle, then predict outputs and the next model state
   task automatic settle();
      bit act, req, wt, adv, fl;
      bit [7:0] en;   // {IR,PC,RA,RB,RZ,RM,RY,ROM1}
      #1;
      act = !Reset && m_running;
      req = act && m_stage == MEMS && Mem_Access;
      wt  = req && !Mem_Ready;
      adv = act && !Stall && !wt;
      fl  = act && Flush && m_stage > 1 && m_stage < N;
      en  = '0;
      if (adv && !fl) begin
         if (m_stage == 1) en = 8'b0111_0000;
         if (m_stage == 2) en = 8'b0000_1100;
         if (m_stage == 3) en = 8'b0000_0010;
         if (m_stage == N) en = 8'b1000_0001;
      end
      exp_done = adv && m_stage == N && m_valid;
      exp_v = {3'(m_stage), en, req, wt, exp_done, 4'(m_count), m_faulted};

      n_stage = m_stage; n_running = m_running; n_faulted = m_faulted;
      n_valid = m_valid; n_waits = m_waits; n_count = m_count;
      if (Reset) begin
         n_stage = N; n_running = 0; n_faulted = 0; n_valid = 0; n_waits = 0; n_count = 0;
      end else if (m_faulted) begin
         n_faulted = 1;
      end else if (!m_running) begin
         if (Run) n_running = 1;
      end else if (wt && m_waits == TMO) begin
         n_faulted = 1; n_running = 0;
      end else if (fl) begin
         n_stage = N; n_valid = 0; n_waits = 0;
      end else if (wt) begin
         n_waits = m_waits + 1;
      end else if (adv) begin
         n_waits = 0;
         if (m_stage == N) begin
            if (m_valid) n_count = (m_count + 1) % (1 << CW);
            n_valid = 0;
            if (Run) n_stage = 1; else n_running = 0;
         end else begin
            if (m_stage == 1) n_valid = 1;
            n_stage = m_stage + 1;
         end
      end
   endtask

   task automatic clock();
      @(posedge Clock);
      m_stage = n_stage; m_running = n_running; m_faulted = n_faulted;
      m_valid = n_valid; m_waits = n_waits; m_count = n_count;
      @(negedge Clock);
   endtask

   // Step (unchecked) until the model sits in the target stage while running
   task automatic goto_stage(input int target, output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         settle();
         if (m_running && m_stage == target) begin
            ok = 1;
            return;
         end
         clock();
      end
   endtask

   task automatic test_reset();
      Reset = 1; Run = 0; Stall = 0; Flush = 0; Mem_Access = 0; Mem_Ready = 0;
      settle(); clock();
      settle();
      checks++;
      if (obs() !== {3'd5, 16'h0}) $display("FAIL reset_state: got %h expected %h", obs(), {3'd5, 16'h0});
      else passed++;
      clock();
      Reset = 0;
      settle();
      checks++;
      if (obs() !== exp_v) $display("FAIL reset_idle: got %h expected %h", obs(), exp_v);
      else passed++;
      clock();
   endtask

   task automatic test_run_sequence();
      int dones = 0;
      Run = 1;
      for (int c = 0; c < 80 && dones < 10; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL run_seq: got %h expected %h", obs(), exp_v);
         else passed++;
         if (Instr_Done === 1'b1) dones++;
         clock();
      end
      settle();
      checks++;
      if (dones != 10 || Instr_Count !== 4'd10)
         $display("FAIL run_count: got dones=%0d count=%0d expected 10/10", dones, Instr_Count);
      else passed++;
   endtask

   task automatic test_mem_wait();
      bit ok;
      Mem_Access = 0; Mem_Ready = 0;
      goto_stage(MEMS, ok);
      checks++;
      if (!ok) $display("FAIL mem_reach: got no stage %0d expected reached", MEMS);
      else passed++;
      Mem_Access = 1;
      for (int c = 0; c < 4; c++) begin
         Mem_Ready = (c == 3);
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL mem_wait: got %h expected %h", obs(), exp_v);
         else passed++;
         if (c < 3) begin
            checks++;
            if ({Mem_Req, Mem_Wait, Stage} !== {2'b11, 3'd4})
               $display("FAIL mem_hold: got %b expected 11100", {Mem_Req, Mem_Wait, Stage});
            else passed++;
         end
         clock();
      end
      Mem_Access = 0; Mem_Ready = 0;
      settle();
      checks++;
      if (Stage !== 3'd5) $display("FAIL mem_release: got %0d expected 5", Stage);
      else passed++;
   endtask

   task automatic test_timeout();
      bit ok;
      // Ready on the last allowed cycle still completes
      goto_stage(MEMS, ok);
      checks++;
      if (!ok) $display("FAIL tmo_reach: got no stage %0d expected reached", MEMS);
      else passed++;
      Mem_Access = 1;
      for (int c = 0; c <= TMO; c++) begin
         Mem_Ready = (c == TMO);
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL tmo_edge: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
      Mem_Access = 0; Mem_Ready = 0;
      settle();
      checks++;
      if (Fault !== 1'b0 || Stage !== 3'd5) $display("FAIL tmo_ready_wins: got fault=%b stage=%0d expected 0/5", Fault, Stage);
      else passed++;
      // Ready never comes: fault after the allowed wait
      goto_stage(MEMS, ok);
      Mem_Access = 1;
      for (int c = 0; c <= TMO; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL tmo_wait: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
      settle();
      checks++;
      if (Fault !== 1'b1) $display("FAIL tmo_fault: got %b expected 1", Fault);
      else passed++;
      for (int c = 0; c < 6; c++) begin
         Run = $urandom_range(0, 1); Stall = $urandom_range(0, 1); Flush = $urandom_range(0, 1);
         Mem_Ready = $urandom_range(0, 1);
         settle();
         checks++;
         if (obs() !== exp_v || {IR_Enable, PC_Enable, RY_Enable, ROM1_Read} !== 4'b0)
            $display("FAIL fault_sticky: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
      Reset = 1; Run = 0; Stall = 0; Flush = 0; Mem_Access = 0; Mem_Ready = 0;
      settle(); clock();
      Reset = 0;
      settle();
      checks++;
      if (Fault !== 1'b0 || Instr_Count !== 4'd0 || Stage !== 3'd5)
         $display("FAIL fault_clear: got fault=%b count=%0d stage=%0d expected 0/0/5", Fault, Instr_Count, Stage);
      else passed++;
   endtask

   task automatic test_flush();
      bit ok;
      Run = 1;
      goto_stage(3, ok);
      checks++;
      if (!ok) $display("FAIL flush_reach: got no stage 3 expected reached");
      else passed++;
      Flush = 1;
      settle();
      checks++;
      if (obs() !== exp_v || RY_Enable !== 1'b0) $display("FAIL flush_cycle: got %h expected %h", obs(), exp_v);
      else passed++;
      clock();
      Flush = 0;
      settle();
      checks++;
      if (Stage !== 3'd5 || IR_Enable !== 1'b1 || Instr_Done !== 1'b0)
         $display("FAIL flush_refetch: got stage=%0d ir=%b done=%b expected 5/1/0", Stage, IR_Enable, Instr_Done);
      else passed++;
      clock();
   endtask

   task automatic test_stall_stop();
      bit ok;
      goto_stage(1, ok);
      Stall = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v || Stage !== 3'd1 || PC_Enable !== 1'b0)
            $display("FAIL stall_hold: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
      Stall = 0;
      goto_stage(3, ok);
      checks++;
      if (!ok) $display("FAIL stall_reach: got no stage 3 expected reached");
      else passed++;
      Run = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL stop_drain: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
         if (!m_running) break;
      end
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v || Stage !== 3'd5 || IR_Enable !== 1'b0)
            $display("FAIL stop_idle: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
   endtask

   task automatic test_wrap();
      int dones = 0;
      bit ok;
      Reset = 1; settle(); clock(); Reset = 0;
      Run = 1;
      for (int c = 0; c < 110 && dones < 17; c++) begin
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL wrap_run: got %h expected %h", obs(), exp_v);
         else passed++;
         if (Instr_Done === 1'b1) dones++;
         clock();
      end
      settle();
      checks++;
      if (Instr_Count !== 4'd1) $display("FAIL wrap_count: got %0d expected 1", Instr_Count);
      else passed++;
      goto_stage(2, ok);
      Reset = 1; Run = 0;
      settle();
      checks++;
      if (obs() !== exp_v) $display("FAIL wrap_reset_cycle: got %h expected %h", obs(), exp_v);
      else passed++;
      clock();
      Reset = 0;
      settle();
      checks++;
      if (obs() !== {3'd5, 16'h0}) $display("FAIL wrap_reset: got %h expected %h", obs(), {3'd5, 16'h0});
      else passed++;
      clock();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         Reset      = ($urandom_range(0, 149) == 0);
         Run        = ($urandom_range(0, 9) != 0);
         Stall      = ($urandom_range(0, 4) == 0);
         Flush      = ($urandom_range(0, 9) == 0);
         Mem_Access = $urandom_range(0, 1);
         Mem_Ready  = ((c % 100) < 25) ? 1'b0 : 1'($urandom_range(0, 1));
         settle();
         checks++;
         if (obs() !== exp_v) $display("FAIL random: got %h expected %h", obs(), exp_v);
         else passed++;
         clock();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_run_sequence();
      test_mem_wait();
      test_timeout();
      test_flush();
      test_stall_stop();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
